// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger: sequencer states
// and the LED thermometer-bar scaling.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_e;

    localparam int unsigned LED_STEP  = 11662;
    localparam int unsigned LED_COUNT = 16;

    // Echo width at which bar segment idx lights; kept 64 bits wide so it cannot overflow.
    function automatic logic [63:0] led_threshold(input int unsigned idx);
        return 64'(idx + 1) * 64'(LED_STEP);
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Consumer-facing control/result bundle of the ultrasonic ranger.
// The consumer side (master) requests measurements; the ranger (slave) publishes results.
interface ultrasonic_ranger_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             start;
    logic             auto_en;
    logic [CNT_W-1:0] echo_cycles;
    logic             dist_valid;
    logic             timeout;
    logic             busy;

    modport master (
        output start,
        output auto_en,
        input  echo_cycles,
        input  dist_valid,
        input  timeout,
        input  busy
    );

    modport slave (
        input  start,
        input  auto_en,
        output echo_cycles,
        output dist_valid,
        output timeout,
        output busy
    );
endinterface

// File: rtl/ultrasonic_echo_sync.sv
// Two-flop synchronizer bringing the asynchronous echo pin into the clk domain.
module ultrasonic_echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: trigger pulse, echo timing with timeout, single-shot and periodic modes.
// Optional thermometer LED bar is built only when ULTRASONIC_LED_BAR_EN is defined.
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned PERIOD_CYCLES  = 20000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ultrasonic_in,
    output logic                 ctrl_ultrasonic,
    output logic [LED_COUNT-1:0] led,
    ultrasonic_ranger_if.slave   bus
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ONE      = cnt_t'(1);
    localparam cnt_t TRIG_LAST    = cnt_t'(TRIG_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
    localparam cnt_t PERIOD_LAST  = cnt_t'(PERIOD_CYCLES - 1);

    // Holdoff must always be reached before the next period boundary.
    if (TRIG_CYCLES < 1) begin : g_bad_trig
        $error("ultrasonic_ranger: TRIG_CYCLES must be at least 1");
    end
    if (PERIOD_CYCLES <= TRIG_CYCLES + 2 * TIMEOUT_CYCLES + 4) begin : g_bad_period
        $error("ultrasonic_ranger: PERIOD_CYCLES must exceed TRIG_CYCLES + 2*TIMEOUT_CYCLES + 4");
    end

    logic   echo_s;
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    cnt_t   period_q, period_d;
    logic   ctrl_q, ctrl_d;
    cnt_t   echo_cycles_q, echo_cycles_d;
    logic   timeout_q, timeout_d;
    logic   dist_valid_q, dist_valid_d;

    ultrasonic_echo_sync u_echo_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ultrasonic_in),
        .sync_out (echo_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            period_q      <= '0;
            ctrl_q        <= 1'b0;
            echo_cycles_q <= '0;
            timeout_q     <= 1'b0;
            dist_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            ctrl_q        <= ctrl_d;
            echo_cycles_q <= echo_cycles_d;
            timeout_q     <= timeout_d;
            dist_valid_q  <= dist_valid_d;
        end
    end

    // cnt_q is reused as trigger width, rise wait and echo width counter.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        ctrl_d        = 1'b0;
        echo_cycles_d = echo_cycles_q;
        timeout_d     = timeout_q;
        dist_valid_d  = 1'b0;

        if (state_q != ST_IDLE) begin
            period_d = period_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start || bus.auto_en) begin
                    state_d  = ST_TRIG;
                    cnt_d    = '0;
                    period_d = '0;
                    ctrl_d   = 1'b1;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    ctrl_d = 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_HOLDOFF;
                    echo_cycles_d = '0;
                    timeout_d     = 1'b1;
                    dist_valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    state_d       = ST_HOLDOFF;
                    echo_cycles_d = cnt_q;
                    timeout_d     = 1'b0;
                    dist_valid_d  = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_HOLDOFF;
                    echo_cycles_d = '0;
                    timeout_d     = 1'b1;
                    dist_valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (period_q == PERIOD_LAST) begin
                    if (bus.auto_en) begin
                        state_d  = ST_TRIG;
                        cnt_d    = '0;
                        period_d = '0;
                        ctrl_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ctrl_ultrasonic = ctrl_q;
    assign bus.echo_cycles = echo_cycles_q;
    assign bus.timeout     = timeout_q;
    assign bus.dist_valid  = dist_valid_q;
    assign bus.busy        = (state_q != ST_IDLE);

`ifdef ULTRASONIC_LED_BAR_EN
    logic [LED_COUNT-1:0] led_q, led_d;

    // Bar follows the freshly published result one cycle after the strobe.
    always_comb begin
        led_d = led_q;
        if (dist_valid_q) begin
            for (int unsigned i = 0; i < LED_COUNT; i++) begin
                led_d[i] = !timeout_q && (64'(echo_cycles_q) >= led_threshold(i));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;
`else
    assign led = '0;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger (TRIG=4, TIMEOUT=50, PERIOD=200).
// With ULTRASONIC_LED_BAR_EN defined, a second instance exercises the LED bar.
module tb_ultrasonic_ranger;

    localparam int TRIG    = 4;
    localparam int TMO     = 50;
    localparam int PERIOD  = 200;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        pin   = 1'b0;
    logic        ctrl;
    logic [15:0] led;

    ultrasonic_ranger_if #(.CNT_W(32)) bus ();

    ultrasonic_ranger #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .PERIOD_CYCLES  (PERIOD),
        .CNT_W          (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ultrasonic_in   (pin),
        .ctrl_ultrasonic (ctrl),
        .led             (led),
        .bus             (bus)
    );

`ifdef ULTRASONIC_LED_BAR_EN
    logic        pin_led = 1'b0;
    logic        ctrl_led;
    logic [15:0] led_led;

    ultrasonic_ranger_if #(.CNT_W(32)) bus_led ();

    ultrasonic_ranger #(
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (30000),
        .PERIOD_CYCLES  (70000),
        .CNT_W          (32)
    ) dut_led (
        .clk             (clk),
        .reset           (reset),
        .ultrasonic_in   (pin_led),
        .ctrl_ultrasonic (ctrl_led),
        .led             (led_led),
        .bus             (bus_led)
    );
`endif

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Cycle-level observer, sampled on the falling edge.
    int   cyc           = 0;
    int   trig_rises    = 0;
    int   ctrl_high     = 0;
    int   valid_cnt     = 0;
    int   last_rise_cyc = 0;
    int   last_fall_cyc = 0;
    int   last_valid_cyc = 0;
    logic ctrl_prev     = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        ctrl_prev <= ctrl;
        if (ctrl && !ctrl_prev) begin
            trig_rises    <= trig_rises + 1;
            last_rise_cyc <= cyc + 1;
        end
        if (!ctrl && ctrl_prev) begin
            last_fall_cyc <= cyc + 1;
        end
        if (ctrl) begin
            ctrl_high <= ctrl_high + 1;
        end
        if (bus.dist_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc + 1;
        end
    end

    typedef struct {
        int delay;
        int width;
        int exp_echo;
        bit exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitTrigDone(input int r0, input string name);
        int n = 0;
        while (!(trig_rises > r0 && ctrl == 1'b0) && n < 40) begin
            tick();
            n++;
        end
        checkOutput(name, 64'(trig_rises > r0 && ctrl == 1'b0), 64'd1);
    endtask

    task automatic waitValid(input int v0, input string name);
        int n = 0;
        while (valid_cnt == v0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput(name, 64'(valid_cnt != v0), 64'd1);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        checkOutput(name, 64'(bus.busy), 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int r0, v0, h0;
        r0 = trig_rises;
        v0 = valid_cnt;
        h0 = ctrl_high;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        waitTrigDone(r0, $sformatf("vec%0d trigger done", idx));
        tick(v.delay);
        if (v.width > 0) begin
            pin = 1'b1;
            tick(v.width);
            pin = 1'b0;
        end
        waitValid(v0, $sformatf("vec%0d strobe seen", idx));
        checkOutput($sformatf("vec%0d echo_cycles", idx), 64'(bus.echo_cycles), 64'(v.exp_echo));
        checkOutput($sformatf("vec%0d timeout", idx), 64'(bus.timeout), 64'(v.exp_to));
        waitIdle($sformatf("vec%0d back to idle", idx));
        checkOutput($sformatf("vec%0d strobe count", idx), 64'(valid_cnt - v0), 64'd1);
        checkOutput($sformatf("vec%0d trigger width", idx), 64'(ctrl_high - h0), 64'(TRIG));
        checkOutput($sformatf("vec%0d trigger count", idx), 64'(trig_rises - r0), 64'd1);
    endtask

    initial begin
        int r0, v0, h0, s0, n;
        int rise_at[3];

        vecs[0] = '{delay: 3,  width: 20, exp_echo: 20, exp_to: 1'b0};
        vecs[1] = '{delay: 0,  width: 1,  exp_echo: 1,  exp_to: 1'b0};
        vecs[2] = '{delay: 10, width: 49, exp_echo: 49, exp_to: 1'b0};
        vecs[3] = '{delay: 5,  width: 50, exp_echo: 0,  exp_to: 1'b1};
        vecs[4] = '{delay: 7,  width: 33, exp_echo: 33, exp_to: 1'b0};
        vecs[5] = '{delay: 0,  width: 0,  exp_echo: 0,  exp_to: 1'b1};

        bus.start   = 1'b0;
        bus.auto_en = 1'b0;
`ifdef ULTRASONIC_LED_BAR_EN
        bus_led.start   = 1'b0;
        bus_led.auto_en = 1'b0;
`endif
        tick(3);
        reset = 1'b0;
        tick();

        checkOutput("reset ctrl", 64'(ctrl), 64'd0);
        checkOutput("reset echo_cycles", 64'(bus.echo_cycles), 64'd0);
        checkOutput("reset dist_valid", 64'(bus.dist_valid), 64'd0);
        checkOutput("reset timeout", 64'(bus.timeout), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset led", 64'(led), 64'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Trigger latency, a start request ignored while busy, and no-echo timeout timing.
        r0 = trig_rises;
        v0 = valid_cnt;
        s0 = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        waitTrigDone(r0, "latency trigger done");
        checkOutput("start to trigger latency", 64'(last_rise_cyc - s0), 64'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        waitValid(v0, "no-echo strobe seen");
        checkOutput("no-echo strobe delay", 64'(last_valid_cyc - last_fall_cyc), 64'(TMO));
        checkOutput("no-echo timeout", 64'(bus.timeout), 64'd1);
        waitIdle("no-echo idle");
        checkOutput("busy start ignored", 64'(trig_rises - r0), 64'd1);

        // Echo pin stuck high from before the trigger.
        r0 = trig_rises;
        v0 = valid_cnt;
        pin = 1'b1;
        tick(3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        waitValid(v0, "stuck strobe seen");
        checkOutput("stuck timeout", 64'(bus.timeout), 64'd1);
        checkOutput("stuck echo_cycles", 64'(bus.echo_cycles), 64'd0);
        waitIdle("stuck idle");
        checkOutput("stuck holdoff end", 64'(cyc - last_rise_cyc), 64'(PERIOD));
        pin = 1'b0;
        tick(5);

        // Auto mode, also raising start alongside auto_en; auto_en dropped during the third period.
        r0 = trig_rises;
        v0 = valid_cnt;
        h0 = ctrl_high;
        bus.start   = 1'b1;
        bus.auto_en = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (trig_rises <= r0 + p && n < 300) begin
                tick();
                n++;
            end
            rise_at[p] = last_rise_cyc;
            if (p == 2) begin
                bus.auto_en = 1'b0;
            end
            waitTrigDone(r0 + p, $sformatf("auto%0d trigger done", p));
            tick(3);
            pin = 1'b1;
            tick(10);
            pin = 1'b0;
            waitValid(v0 + p, $sformatf("auto%0d strobe seen", p));
            checkOutput($sformatf("auto%0d echo_cycles", p), 64'(bus.echo_cycles), 64'd10);
            checkOutput($sformatf("auto%0d timeout", p), 64'(bus.timeout), 64'd0);
        end
        waitIdle("auto idle");
        tick(20);
        checkOutput("auto trigger count", 64'(trig_rises - r0), 64'd3);
        checkOutput("auto strobe count", 64'(valid_cnt - v0), 64'd3);
        checkOutput("auto trigger width total", 64'(ctrl_high - h0), 64'(3 * TRIG));
        checkOutput("auto spacing 0-1", 64'(rise_at[1] - rise_at[0]), 64'(PERIOD));
        checkOutput("auto spacing 1-2", 64'(rise_at[2] - rise_at[1]), 64'(PERIOD));

        // Reset while the trigger pin is high.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("pre-reset ctrl high", 64'(ctrl), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset in TRIG ctrl", 64'(ctrl), 64'd0);
        checkOutput("reset in TRIG busy", 64'(bus.busy), 64'd0);
        tick();
        reset = 1'b0;
        tick(2);

        // Reset while measuring an echo: result cleared and no strobe.
        r0 = trig_rises;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        waitTrigDone(r0, "reset-measure trigger done");
        pin = 1'b1;
        tick(8);
        v0 = valid_cnt;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset in MEASURE echo_cycles", 64'(bus.echo_cycles), 64'd0);
        checkOutput("reset in MEASURE busy", 64'(bus.busy), 64'd0);
        checkOutput("reset in MEASURE ctrl", 64'(ctrl), 64'd0);
        tick(2);
        pin = 1'b0;
        reset = 1'b0;
        tick(10);
        checkOutput("reset in MEASURE no strobe", 64'(valid_cnt - v0), 64'd0);
        checkOutput("reset in MEASURE stays idle", 64'(bus.busy), 64'd0);
        checkOutput("reset in MEASURE timeout", 64'(bus.timeout), 64'd0);

`ifdef ULTRASONIC_LED_BAR_EN
        bus_led.start = 1'b1;
        tick();
        bus_led.start = 1'b0;
        tick(6);
        checkOutput("led trigger done", 64'(ctrl_led), 64'd0);
        pin_led = 1'b1;
        tick(23324);
        pin_led = 1'b0;
        n = 0;
        while (!bus_led.dist_valid && n < 10) begin
            tick();
            n++;
        end
        checkOutput("led strobe seen", 64'(bus_led.dist_valid), 64'd1);
        checkOutput("led echo_cycles", 64'(bus_led.echo_cycles), 64'd23324);
        tick();
        checkOutput("led bar", 64'(led_led), 64'h0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
